// File: rtl/gpio_pkg.sv
// Shared constants for the GPIO bank: width limit, register map, warm-up length.
package gpio_pkg;

  localparam int unsigned GPIO_WIDTH_MAX = 32;

  // Register indices on the 3-bit bus address.
  typedef enum logic [2:0] {
    REG_DATA_OUT   = 3'd0,
    REG_DIR        = 3'd1,
    REG_DATA_IN    = 3'd2,
    REG_RISE_EN    = 3'd3,
    REG_FALL_EN    = 3'd4,
    REG_IRQ_STATUS = 3'd5,
    REG_SET        = 3'd6,
    REG_CLR        = 3'd7
  } gpio_reg_e;

  // Warm-up count at which prev holds a real sample of the pads.
  localparam logic [1:0] WARMUP_DONE = 2'd3;

endpackage

// File: rtl/gpio_in_sync.sv
// Pad input path: two-stage synchronizer, previous-sample register and
// per-bit edge detection, held off until the pipeline holds valid samples.
module gpio_in_sync
  import gpio_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pad_di,
  output logic [WIDTH-1:0] sync,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] prev;
  logic [1:0]       warm_cnt;
  logic             armed;

  // Synchronizer chain, previous sample and saturating warm-up counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1    <= '0;
      sync2    <= '0;
      prev     <= '0;
      warm_cnt <= '0;
    end else begin
      sync1 <= pad_di;
      sync2 <= sync1;
      prev  <= sync2;
      if (warm_cnt != WARMUP_DONE) begin
        warm_cnt <= warm_cnt + 2'd1;
      end
    end
  end

  // prev is only meaningful once three samples have passed since reset;
  // before that a pad held high would look like a rising edge.
  assign armed = (warm_cnt == WARMUP_DONE);
  assign sync  = sync2;

  // Edge decode against the previous synchronized sample.
  always_comb begin
    rise = '0;
    fall = '0;
    if (armed) begin
      rise = sync2 & ~prev;
      fall = ~sync2 & prev;
    end
  end

endmodule

// File: rtl/gpio_port_ctrl.sv
// GPIO bank controller: register file on the simple bus, pad drive from
// DIR/DATA_OUT, edge-triggered interrupt status with write-1-to-clear.
module gpio_port_ctrl
  import gpio_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       addr,
  input  logic [31:0]      wdata,
  input  logic             we,
  input  logic             re,
  output logic [31:0]      rdata,
  output logic             rvalid,
  output logic             irq,
  output logic [WIDTH-1:0] pad_oe,
  output logic [WIDTH-1:0] pad_do,
  input  logic [WIDTH-1:0] pad_di
);

  gpio_reg_e        reg_sel;
  logic [WIDTH-1:0] wd;
  logic             unused_wdata;

  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] dir;
  logic [WIDTH-1:0] rise_en;
  logic [WIDTH-1:0] fall_en;
  logic [WIDTH-1:0] irq_status;

  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;

  logic [WIDTH-1:0]          status_set;
  logic [WIDTH-1:0]          status_clr;
  logic [GPIO_WIDTH_MAX-1:0] rd_word;

  assign reg_sel      = gpio_reg_e'(addr);
  assign wd           = wdata[WIDTH-1:0];
  assign unused_wdata = ^wdata;

  gpio_in_sync #(
    .WIDTH (WIDTH)
  ) u_in_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .pad_di (pad_di),
    .sync   (data_in),
    .rise   (rise),
    .fall   (fall)
  );

  // Software-writable control registers, including the SET/CLR aliases.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out <= '0;
      dir      <= '0;
      rise_en  <= '0;
      fall_en  <= '0;
    end else if (we) begin
      case (reg_sel)
        REG_DATA_OUT: data_out <= wd;
        REG_DIR:      dir      <= wd;
        REG_RISE_EN:  rise_en  <= wd;
        REG_FALL_EN:  fall_en  <= wd;
        REG_SET:      data_out <= data_out | wd;
        REG_CLR:      data_out <= data_out & ~wd;
        default:      ;
      endcase
    end
  end

  // Per-bit status set from enabled edges and clear from a W1C write.
  always_comb begin
    status_set = (rise & rise_en) | (fall & fall_en);
    status_clr = '0;
    if (we && (reg_sel == REG_IRQ_STATUS)) begin
      status_clr = wd;
    end
  end

  // Status register; the set term is OR'd in last so a new edge wins over
  // a simultaneous clear of the same bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_status <= '0;
    end else begin
      irq_status <= (irq_status & ~status_clr) | status_set;
    end
  end

  // Read mux from current register state, zero-extended to the bus width.
  always_comb begin
    rd_word = '0;
    case (reg_sel)
      REG_DATA_OUT:   rd_word[WIDTH-1:0] = data_out;
      REG_DIR:        rd_word[WIDTH-1:0] = dir;
      REG_DATA_IN:    rd_word[WIDTH-1:0] = data_in;
      REG_RISE_EN:    rd_word[WIDTH-1:0] = rise_en;
      REG_FALL_EN:    rd_word[WIDTH-1:0] = fall_en;
      REG_IRQ_STATUS: rd_word[WIDTH-1:0] = irq_status;
      default:        rd_word = '0;
    endcase
  end

  // Registered read response; rdata holds between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= re;
      if (re) begin
        rdata <= rd_word;
      end
    end
  end

  assign pad_oe = dir;
  assign pad_do = data_out;
  assign irq    = |irq_status;

endmodule
